// File: rtl/spatial_accumulator_mc.sv
// Multi-channel spatial accumulator: sums up to CHANNELS bound hypervectors per bit,
// then thresholds them into a majority hypervector behind valid/ready handshakes.
module spatial_accumulator_mc #(
  parameter int HV_DIMENSION = 1000,
  parameter int CHANNELS     = 4,
  parameter int CNT_WIDTH    = 3,
  parameter int TIE_MODE     = 0
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    InValid_SI,
  output logic                    InReady_SO,
  input  logic                    FirstHypervector_SI,
  input  logic                    LastHypervector_SI,
  input  logic [HV_DIMENSION-1:0] HypervectorIn_DI,
  input  logic [HV_DIMENSION-1:0] TieBreak_DI,
  output logic                    OutValid_SO,
  input  logic                    OutReady_SI,
  output logic [HV_DIMENSION-1:0] HypervectorOut_DO,
  output logic [CNT_WIDTH-1:0]    ChannelCount_DO,
  output logic                    Error_SO
);

  typedef enum logic [1:0] {IDLE, ACCUM, THRESH, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q [HV_DIMENSION];
  logic [CNT_WIDTH-1:0]    cnt_d [HV_DIMENSION];
  logic [CNT_WIDTH-1:0]    n_q, n_d;
  logic [CNT_WIDTH-1:0]    count_out_q, count_out_d;
  logic [HV_DIMENSION-1:0] hv_out_q, hv_out_d;
  logic [HV_DIMENSION-1:0] thresh_hv;
  logic                    out_valid_q, out_valid_d;
  logic                    error_q, error_d;
  logic                    accept;

  assign InReady_SO        = (state_q == IDLE) || (state_q == ACCUM);
  assign accept            = InValid_SI && InReady_SO;
  assign OutValid_SO       = out_valid_q;
  assign HypervectorOut_DO = hv_out_q;
  assign ChannelCount_DO   = count_out_q;
  assign Error_SO          = error_q;

  // Majority compare at CNT_WIDTH+1 bits: 2*count against n, equality resolved by TIE_MODE.
  always_comb begin
    thresh_hv = '0;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      if ({cnt_q[i], 1'b0} > {1'b0, n_q}) begin
        thresh_hv[i] = 1'b1;
      end else if ({cnt_q[i], 1'b0} < {1'b0, n_q}) begin
        thresh_hv[i] = 1'b0;
      end else if (TIE_MODE == 1) begin
        thresh_hv[i] = 1'b1;
      end else if (TIE_MODE == 2) begin
        thresh_hv[i] = TieBreak_DI[i];
      end else begin
        thresh_hv[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    hv_out_d    = hv_out_q;
    count_out_d = count_out_q;
    out_valid_d = out_valid_q;
    error_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (FirstHypervector_SI) begin
            for (int i = 0; i < HV_DIMENSION; i++) begin
              cnt_d[i] = CNT_WIDTH'(HypervectorIn_DI[i]);
            end
            n_d     = CNT_WIDTH'(1);
            state_d = (LastHypervector_SI || CHANNELS == 1) ? THRESH : ACCUM;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          // A new First beat aborts the partial sample and starts over from this beat.
          if (FirstHypervector_SI) begin
            for (int i = 0; i < HV_DIMENSION; i++) begin
              cnt_d[i] = CNT_WIDTH'(HypervectorIn_DI[i]);
            end
            n_d     = CNT_WIDTH'(1);
            error_d = 1'b1;
            state_d = (LastHypervector_SI || CHANNELS == 1) ? THRESH : ACCUM;
          end else begin
            for (int i = 0; i < HV_DIMENSION; i++) begin
              cnt_d[i] = cnt_q[i] + CNT_WIDTH'(HypervectorIn_DI[i]);
            end
            n_d = n_q + 1'b1;
            if (LastHypervector_SI || n_d == CNT_WIDTH'(CHANNELS)) begin
              state_d = THRESH;
            end
          end
        end
      end

      THRESH: begin
        hv_out_d    = thresh_hv;
        count_out_d = n_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end

      HOLD: begin
        if (OutReady_SI) begin
          out_valid_d = 1'b0;
          for (int i = 0; i < HV_DIMENSION; i++) begin
            cnt_d[i] = '0;
          end
          n_d     = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q     <= IDLE;
      for (int i = 0; i < HV_DIMENSION; i++) begin
        cnt_q[i] <= '0;
      end
      n_q         <= '0;
      hv_out_q    <= '0;
      count_out_q <= '0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < HV_DIMENSION; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      n_q         <= n_d;
      hv_out_q    <= hv_out_d;
      count_out_q <= count_out_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_spatial_accumulator_mc.sv
// Directed bench for spatial_accumulator_mc: four instances with different CHANNELS/TIE_MODE
// share one stimulus bus; each vector checks only the instance it targets.
module tb_spatial_accumulator_mc;

  localparam int HV = 10;
  localparam int CW = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                first = 1'b0;
  logic                last = 1'b0;
  logic [HV-1:0]       hv_in = '0;
  logic [HV-1:0]       tie = '0;
  logic                out_ready = 1'b0;

  logic [3:0]          in_ready;
  logic [3:0]          out_valid;
  logic [3:0][HV-1:0]  hv_out;
  logic [3:0][CW-1:0]  cnt_out;
  logic [3:0]          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: CH=3 TIE=0, 1: CH=4 TIE=2, 2: CH=4 TIE=1, 3: CH=1 TIE=0
  spatial_accumulator_mc #(.HV_DIMENSION(HV), .CHANNELS(3), .CNT_WIDTH(CW), .TIE_MODE(0)) dut_a (
    .Clk_CI(clk), .Reset_RI(rst), .InValid_SI(in_valid), .InReady_SO(in_ready[0]),
    .FirstHypervector_SI(first), .LastHypervector_SI(last), .HypervectorIn_DI(hv_in),
    .TieBreak_DI(tie), .OutValid_SO(out_valid[0]), .OutReady_SI(out_ready),
    .HypervectorOut_DO(hv_out[0]), .ChannelCount_DO(cnt_out[0]), .Error_SO(err[0]));

  spatial_accumulator_mc #(.HV_DIMENSION(HV), .CHANNELS(4), .CNT_WIDTH(CW), .TIE_MODE(2)) dut_b (
    .Clk_CI(clk), .Reset_RI(rst), .InValid_SI(in_valid), .InReady_SO(in_ready[1]),
    .FirstHypervector_SI(first), .LastHypervector_SI(last), .HypervectorIn_DI(hv_in),
    .TieBreak_DI(tie), .OutValid_SO(out_valid[1]), .OutReady_SI(out_ready),
    .HypervectorOut_DO(hv_out[1]), .ChannelCount_DO(cnt_out[1]), .Error_SO(err[1]));

  spatial_accumulator_mc #(.HV_DIMENSION(HV), .CHANNELS(4), .CNT_WIDTH(CW), .TIE_MODE(1)) dut_c (
    .Clk_CI(clk), .Reset_RI(rst), .InValid_SI(in_valid), .InReady_SO(in_ready[2]),
    .FirstHypervector_SI(first), .LastHypervector_SI(last), .HypervectorIn_DI(hv_in),
    .TieBreak_DI(tie), .OutValid_SO(out_valid[2]), .OutReady_SI(out_ready),
    .HypervectorOut_DO(hv_out[2]), .ChannelCount_DO(cnt_out[2]), .Error_SO(err[2]));

  spatial_accumulator_mc #(.HV_DIMENSION(HV), .CHANNELS(1), .CNT_WIDTH(CW), .TIE_MODE(0)) dut_d (
    .Clk_CI(clk), .Reset_RI(rst), .InValid_SI(in_valid), .InReady_SO(in_ready[3]),
    .FirstHypervector_SI(first), .LastHypervector_SI(last), .HypervectorIn_DI(hv_in),
    .TieBreak_DI(tie), .OutValid_SO(out_valid[3]), .OutReady_SI(out_ready),
    .HypervectorOut_DO(hv_out[3]), .ChannelCount_DO(cnt_out[3]), .Error_SO(err[3]));

  typedef struct packed {
    logic [1:0]         dut;
    logic [2:0]         nbeats;
    logic               use_last;
    logic [2:0][HV-1:0] beats;
    logic [HV-1:0]      tie;
    logic [HV-1:0]      exp_hv;
    logic [CW-1:0]      exp_n;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic [1:0] d, input logic [2:0] nb, input logic ul,
                              input logic [HV-1:0] b0, input logic [HV-1:0] b1,
                              input logic [HV-1:0] b2, input logic [HV-1:0] t,
                              input logic [HV-1:0] eh, input logic [CW-1:0] en);
    vec_t v;
    v.dut = d; v.nbeats = nb; v.use_last = ul;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = b2;
    v.tie = t; v.exp_hv = eh; v.exp_n = en;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1; in_valid = 1'b0; first = 1'b0; last = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [HV-1:0] b, input logic f, input logic l);
    in_valid = 1'b1; first = f; last = l; hv_in = b;
    tick();
    in_valid = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   d;
    vecs[0] = mk(0, 3, 0, 10'b1010101010, 10'b1100110011, 10'b1111100000, 10'b0000000000, 10'b1110100010, 3);
    vecs[1] = mk(1, 2, 1, 10'b1010101010, 10'b1100110011, 10'b0, 10'b0000000000, 10'b1000100010, 2);
    vecs[2] = mk(1, 2, 1, 10'b1010101010, 10'b1100110011, 10'b0, 10'b1111111111, 10'b1110111011, 2);
    vecs[3] = mk(2, 2, 1, 10'b1010101010, 10'b1100110011, 10'b0, 10'b0000000000, 10'b1110111011, 2);
    vecs[4] = mk(3, 1, 0, 10'b0110011001, 10'b0, 10'b0, 10'b0000000000, 10'b0110011001, 1);
    vecs[5] = mk(0, 2, 1, 10'b1010101010, 10'b1100110011, 10'b0, 10'b1111111111, 10'b1000100010, 2);
    vecs[6] = mk(1, 2, 1, 10'b1010101010, 10'b1100110011, 10'b0, 10'b1010101010, 10'b1010101010, 2);

    for (int k = 0; k < 7; k++) begin
      v = vecs[k];
      d = int'(v.dut);
      doReset();
      checkOutput($sformatf("v%0d reset valid", k), 32'(out_valid[d]), 0);
      checkOutput($sformatf("v%0d reset hv", k), 32'(hv_out[d]), 0);
      checkOutput($sformatf("v%0d reset count", k), 32'(cnt_out[d]), 0);
      checkOutput($sformatf("v%0d reset error", k), 32'(err[d]), 0);
      checkOutput($sformatf("v%0d reset inready", k), 32'(in_ready[d]), 1);
      tie = v.tie;
      for (int b = 0; b < int'(v.nbeats); b++) begin
        applyStimulus(v.beats[b], b == 0, v.use_last && (b == int'(v.nbeats) - 1));
      end
      checkOutput($sformatf("v%0d thresh valid low", k), 32'(out_valid[d]), 0);
      checkOutput($sformatf("v%0d thresh inready", k), 32'(in_ready[d]), 0);
      tick();
      checkOutput($sformatf("v%0d valid", k), 32'(out_valid[d]), 1);
      checkOutput($sformatf("v%0d hv", k), 32'(hv_out[d]), 32'(v.exp_hv));
      checkOutput($sformatf("v%0d count", k), 32'(cnt_out[d]), 32'(v.exp_n));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput($sformatf("v%0d valid drop", k), 32'(out_valid[d]), 0);
      checkOutput($sformatf("v%0d inready back", k), 32'(in_ready[d]), 1);
    end

    // Back-pressure on instance 0 with input beats offered during HOLD
    doReset();
    applyStimulus(10'b1010101010, 1, 0);
    applyStimulus(10'b1100110011, 0, 0);
    applyStimulus(10'b1111100000, 0, 0);
    tick();
    checkOutput("bp valid rise", 32'(out_valid[0]), 1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; first = 1'b1; hv_in = 10'b1111111111;
      tick();
      checkOutput($sformatf("bp%0d valid", c), 32'(out_valid[0]), 1);
      checkOutput($sformatf("bp%0d hv", c), 32'(hv_out[0]), 32'(10'b1110100010));
      checkOutput($sformatf("bp%0d count", c), 32'(cnt_out[0]), 3);
      checkOutput($sformatf("bp%0d inready", c), 32'(in_ready[0]), 0);
      checkOutput($sformatf("bp%0d error", c), 32'(err[0]), 0);
    end
    in_valid = 1'b0; first = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("bp release valid", 32'(out_valid[0]), 0);
    checkOutput("bp release inready", 32'(in_ready[0]), 1);
    checkOutput("bp hv kept", 32'(hv_out[0]), 32'(10'b1110100010));
    applyStimulus(10'b0000000000, 1, 0);
    applyStimulus(10'b0000000000, 0, 0);
    applyStimulus(10'b0000000000, 0, 0);
    tick();
    checkOutput("bp fresh valid", 32'(out_valid[0]), 1);
    checkOutput("bp fresh hv", 32'(hv_out[0]), 0);
    checkOutput("bp fresh count", 32'(cnt_out[0]), 3);

    // Protocol error in IDLE, then restart mid-sample
    doReset();
    applyStimulus(10'b1111111111, 0, 0);
    checkOutput("idle err pulse", 32'(err[0]), 1);
    checkOutput("idle err inready", 32'(in_ready[0]), 1);
    checkOutput("idle err valid", 32'(out_valid[0]), 0);
    tick();
    checkOutput("idle err clears", 32'(err[0]), 0);
    applyStimulus(10'b1010101010, 1, 0);
    applyStimulus(10'b1100110011, 0, 0);
    checkOutput("accum no err", 32'(err[0]), 0);
    applyStimulus(10'b1111111111, 1, 0);
    checkOutput("restart err pulse", 32'(err[0]), 1);
    applyStimulus(10'b0000000000, 0, 0);
    checkOutput("restart err clears", 32'(err[0]), 0);
    applyStimulus(10'b1111111111, 0, 0);
    tick();
    checkOutput("restart valid", 32'(out_valid[0]), 1);
    checkOutput("restart hv", 32'(hv_out[0]), 32'(10'b1111111111));
    checkOutput("restart count", 32'(cnt_out[0]), 3);

    // Reset during ACCUM must leave no stale counts
    doReset();
    applyStimulus(10'b1111111111, 1, 0);
    applyStimulus(10'b1111111111, 0, 0);
    doReset();
    checkOutput("midrst valid", 32'(out_valid[0]), 0);
    checkOutput("midrst hv", 32'(hv_out[0]), 0);
    checkOutput("midrst count", 32'(cnt_out[0]), 0);
    checkOutput("midrst error", 32'(err[0]), 0);
    applyStimulus(10'b1010101010, 1, 0);
    applyStimulus(10'b1010101010, 0, 0);
    applyStimulus(10'b1010101010, 0, 0);
    tick();
    checkOutput("midrst fresh valid", 32'(out_valid[0]), 1);
    checkOutput("midrst fresh hv", 32'(hv_out[0]), 32'(10'b1010101010));
    checkOutput("midrst fresh count", 32'(cnt_out[0]), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
